seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 8-tube seven-segment display. It cycles through the eight tubes at a parameterised refresh rate and drives the downstream BCD decode stage with DIGIT, SELECT and PLACE. Four 4-bit values are each shown as a two-digit decimal number: tens on odd tubes, ones on even tubes. Input values are snapshotted once per frame so a displayed number never tears mid-scan.

---
 rtl/seg_scan_ctrl.sv | 75 +++++++
 tb/tb_seg_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-tube seven-segment display.
// Snapshots four 4-bit values per frame and walks the tubes at SCAN_DIV cycles per tube.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | after reset, outputs at zero, waiting for en
// SCAN  | cycling tubes; left only by reset
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] values,
  output logic [3:0]  digit,
  output logic [2:0]  select,
  output logic        place,
  output logic        frame_start
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] presc;
  logic [15:0]      shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      select      <= '0;
      shadow      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state       <= SCAN;
            shadow      <= values;
            select      <= '0;
            presc       <= '0;
            frame_start <= 1'b1;
          end
        end
        default: begin
          // en low holds the prescaler so a resumed tube finishes its remaining dwell
          if (en) begin
            if (presc == DIV_LAST) begin
              presc <= '0;
              if (select == 3'd7) begin
                shadow      <= values;
                select      <= '0;
                frame_start <= 1'b1;
              end else begin
                select <= select + 3'd1;
              end
            end else begin
              presc <= presc + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Tube pair {2k, 2k+1} shows value k; odd tube is the tens place
  assign place = select[0];
  assign digit = shadow[{select[2:1], 2'b00} +: 4];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one DUT at SCAN_DIV=4, a second at SCAN_DIV=1.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [15:0] values_a, values_b;
  logic [3:0]  digit_a, digit_b;
  logic [2:0]  select_a, select_b;
  logic        place_a, place_b;
  logic        fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.SCAN_DIV(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .values(values_a),
    .digit(digit_a), .select(select_a), .place(place_a), .frame_start(fs_a)
  );

  seg_scan_ctrl #(.SCAN_DIV(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .values(values_b),
    .digit(digit_b), .select(select_b), .place(place_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed tuple layout: {select, digit, place, frame_start}
  function automatic logic [8:0] obs_a();
    return {select_a, digit_a, place_a, fs_a};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; values_a = 16'hF9C3; values_b = 16'h0A50;
    #12 rst_n = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a() !== 9'd0 || {select_b, digit_b, place_b, fs_b} !== 9'd0) begin
      errors++;
      $display("FAIL reset_assert got a=%h b=%h exp 000", obs_a(), {select_b, digit_b, place_b, fs_b});
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (obs_a() !== 9'd0 || {select_b, digit_b, place_b, fs_b} !== 9'd0) begin
        errors++;
        $display("FAIL reset_idle k=%0d got a=%h b=%h exp 000", k, obs_a(), {select_b, digit_b, place_b, fs_b});
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] seq [8] = '{4'd3, 4'd3, 4'd12, 4'd12, 4'd9, 4'd9, 4'd15, 4'd15};
    logic [8:0] exp;
    en_a = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      exp = {3'(k / 4), seq[k / 4], 1'((k / 4) % 2), 1'(k == 0)};
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL basic_scan k=%0d got %h exp %h", k, obs_a(), exp);
      end
      tick();
    end
    checks++;
    if (fs_a !== 1'b1 || select_a !== 3'd0) begin
      errors++;
      $display("FAIL basic_period got fs=%b sel=%0d exp fs=1 sel=0", fs_a, select_a);
    end
  endtask

  task automatic test_snapshot();
    logic [3:0] old_seq [8] = '{4'd3, 4'd3, 4'd12, 4'd12, 4'd9, 4'd9, 4'd15, 4'd15};
    logic [3:0] new_seq [8] = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1};
    logic [8:0] exp;
    for (int k = 0; k < 32; k++) begin
      exp = {3'(k / 4), old_seq[k / 4], 1'((k / 4) % 2), 1'(k == 0)};
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL snapshot_old k=%0d got %h exp %h", k, obs_a(), exp);
      end
      if (k == 12) values_a = 16'h1234;
      tick();
    end
    for (int k = 0; k < 32; k++) begin
      exp = {3'(k / 4), new_seq[k / 4], 1'((k / 4) % 2), 1'(k == 0)};
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL snapshot_new k=%0d got %h exp %h", k, obs_a(), exp);
      end
      tick();
    end
  endtask

  task automatic test_freeze();
    for (int k = 0; k < 21; k++) tick();
    en_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (obs_a() !== {3'd5, 4'd2, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL freeze_hold k=%0d got %h exp %h", k, obs_a(), {3'd5, 4'd2, 1'b1, 1'b0});
      end
    end
    en_a = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (select_a !== 3'd5) begin
        errors++;
        $display("FAIL freeze_resume k=%0d got sel=%0d exp 5", k, select_a);
      end
    end
    tick();
    checks++;
    if (obs_a() !== {3'd6, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL freeze_advance got %h exp %h", obs_a(), {3'd6, 4'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_mid_reset();
    #2 rst_n = 1'b0;
    en_a = 1'b0;
    #1;
    checks++;
    if (obs_a() !== 9'd0) begin
      errors++;
      $display("FAIL midreset_async got %h exp 000", obs_a());
    end
    tick();
    rst_n = 1'b1;
    values_a = 16'h5678;
    tick();
    checks++;
    if (obs_a() !== 9'd0) begin
      errors++;
      $display("FAIL midreset_idle got %h exp 000", obs_a());
    end
    en_a = 1'b1;
    tick();
    checks++;
    if (obs_a() !== {3'd0, 4'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midreset_load got %h exp %h", obs_a(), {3'd0, 4'd8, 1'b0, 1'b1});
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (obs_a() !== {3'd1, 4'd8, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midreset_tube1 got %h exp %h", obs_a(), {3'd1, 4'd8, 1'b1, 1'b0});
    end
  endtask

  task automatic test_div1();
    logic [3:0] seq [8] = '{4'd0, 4'd0, 4'd5, 4'd5, 4'd10, 4'd10, 4'd0, 4'd0};
    logic [8:0] exp;
    en_b = 1'b1;
    tick();
    for (int k = 0; k < 24; k++) begin
      exp = {3'(k % 8), seq[k % 8], 1'(k % 2), 1'(k % 8 == 0)};
      checks++;
      if ({select_b, digit_b, place_b, fs_b} !== exp) begin
        errors++;
        $display("FAIL div1 k=%0d got %h exp %h", k, {select_b, digit_b, place_b, fs_b}, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_freeze();
    test_mid_reset();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
